// File: rtl/sqrt_iter_pkg.sv
// sqrt_iter_pkg: shared default root width and controller state encoding.
package sqrt_iter_pkg;
  localparam int W_DEF = 128;
  typedef enum logic {IDLE, CALC} state_t;
endpackage

// File: rtl/sqrt_iter_step.sv
// sqrt_step: one restoring square-root iteration, bringing down two radicand bits and producing one root bit.
module sqrt_step #(
  parameter int W = sqrt_iter_pkg::W_DEF
) (
  input  logic [W+1:0] r,
  input  logic [W-1:0] q,
  input  logic [1:0]   bits,
  output logic [W+1:0] r_next,
  output logic [W-1:0] q_next
);
  logic [W+1:0] rs;
  logic [W+2:0] t;
  assign rs = (r << 2) | {{W{1'b0}}, bits};
  // one extra bit so the borrow of the trial subtraction is the sign
  assign t = {1'b0, rs} - {1'b0, q, 2'b01};
  assign r_next = t[W+2] ? rs : t[W+1:0];
  assign q_next = (q << 1) | {{(W-1){1'b0}}, ~t[W+2]};
endmodule

// File: rtl/sqrt_iter.sv
// sqrt_iter: iterative floor square root of a 2*W-bit radicand, one root bit per clock.
module sqrt_iter
  import sqrt_iter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] a,
  output logic [W-1:0]   root,
  output logic [W:0]     rem,
  output logic           done,
  output logic           busy
);
  localparam int CW = $clog2(W);
  state_t state, state_n;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] opd;
  logic [W+1:0]   r, r_n;
  logic [W-1:0]   q, q_n;
  sqrt_step #(.W(W)) u_step (
    .r(r), .q(q), .bits(opd[2*W-1:2*W-2]), .r_next(r_n), .q_next(q_n)
  );
  assign busy = (state == CALC);
  always_comb begin
    state_n = state;
    if (state == IDLE && start) state_n = CALC;
    else if (state == CALC && cnt == '0) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      opd   <= '0;
      r     <= '0;
      q     <= '0;
      root  <= '0;
      rem   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      if (state == IDLE && start) begin
        opd <= a;
        r   <= '0;
        q   <= '0;
        cnt <= CW'(W - 1);
      end else if (state == CALC) begin
        opd <= opd << 2;
        r   <= r_n;
        q   <= q_n;
        cnt <= cnt - CW'(1);
        if (cnt == '0) begin
          root <= q_n;
          rem  <= r_n[W:0];
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sqrt_iter.sv
// tb_sqrt_iter: directed checks of sqrt_iter at W=128 plus an exhaustive W=4 instance.
module tb_sqrt_iter;
  localparam int W = 128;
  logic clk = 0, rst = 1, start = 0, start4 = 0;
  logic [2*W-1:0] a = '0;
  logic [W-1:0] root;
  logic [W:0] rem;
  logic done, busy;
  logic [7:0] a4 = '0;
  logic [3:0] root4;
  logic [4:0] rem4;
  logic done4, busy4;
  int vec = 0, errs = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a),
    .root(root), .rem(rem), .done(done), .busy(busy)
  );
  sqrt_iter #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4),
    .root(root4), .rem(rem4), .done(done4), .busy(busy4)
  );

  task automatic kick(input logic [2*W-1:0] v);
    @(negedge clk);
    a = v;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!done && n < 400);
    if (!done) begin
      vec++; errs++;
      $display("FAIL done_timeout: no done after %0d cycles", n);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1 vec++;
    if ({root, rem, done, busy} !== '0) begin
      errs++;
      $display("FAIL reset_outputs: root=%0h rem=%0h done=%b busy=%b, want all 0", root, rem, done, busy);
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_basic;
    int n;
    kick(9);
    vec++;
    if (busy !== 1'b1) begin errs++; $display("FAIL busy_after_start: got %b want 1", busy); end
    wait_done(n);
    vec++; if (n !== 128) begin errs++; $display("FAIL latency_9: got %0d want 128", n); end
    vec++; if (root !== 3) begin errs++; $display("FAIL root_9: got %0d want 3", root); end
    vec++; if (rem !== 0) begin errs++; $display("FAIL rem_9: got %0d want 0", rem); end
    @(posedge clk); #1;
    vec++; if (done !== 1'b0) begin errs++; $display("FAIL done_pulse_width: got %b want 0", done); end
    vec++; if (root !== 3 || busy !== 1'b0) begin errs++; $display("FAIL hold_after_done: root=%0d busy=%b want 3/0", root, busy); end
    kick(10);
    wait_done(n);
    vec++; if (root !== 3 || rem !== 1) begin errs++; $display("FAIL result_10: root=%0d rem=%0d want 3/1", root, rem); end
  endtask

  task automatic test_extremes;
    int n;
    logic [W-1:0] rmax;
    logic [W:0] qmax;
    rmax = '1;
    qmax = {1'b1, {W{1'b0}}} - (W+1)'(1);
    qmax = qmax << 1;
    kick(0);
    wait_done(n);
    vec++; if (root !== 0 || rem !== 0) begin errs++; $display("FAIL result_0: root=%0h rem=%0h want 0/0", root, rem); end
    kick('1);
    wait_done(n);
    vec++; if (root !== rmax) begin errs++; $display("FAIL root_max: got %0h want %0h", root, rmax); end
    vec++; if (rem !== qmax) begin errs++; $display("FAIL rem_max: got %0h want %0h", rem, qmax); end
  endtask

  task automatic test_ignore_start;
    int dones = 0, busy_bad = 0, at = -1;
    kick(100);
    for (int i = 1; i <= 140; i++) begin
      @(posedge clk);
      #1;
      if (done) begin dones++; at = i; end
      if (i < 128 && busy !== 1'b1) busy_bad++;
      start = (i == 4 || i == 39);
      if (start) a = 49;
    end
    vec++; if (dones !== 1) begin errs++; $display("FAIL ignore_done_count: got %0d want 1", dones); end
    vec++; if (at !== 128) begin errs++; $display("FAIL ignore_latency: got %0d want 128", at); end
    vec++; if (busy_bad !== 0) begin errs++; $display("FAIL ignore_busy: %0d cycles low, want 0", busy_bad); end
    vec++; if (root !== 10 || rem !== 0) begin errs++; $display("FAIL ignore_result: root=%0d rem=%0d want 10/0", root, rem); end
  endtask

  task automatic test_back_to_back;
    int n;
    kick(144);
    wait_done(n);
    vec++; if (root !== 12 || rem !== 0) begin errs++; $display("FAIL b2b_first: root=%0d rem=%0d want 12/0", root, rem); end
    a = 12345 * 12345 + 7;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    vec++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_accept: busy=%b want 1", busy); end
    wait_done(n);
    vec++; if (n !== 128) begin errs++; $display("FAIL b2b_latency: got %0d want 128", n); end
    vec++; if (root !== 12345 || rem !== 7) begin errs++; $display("FAIL b2b_second: root=%0d rem=%0d want 12345/7", root, rem); end
  endtask

  task automatic test_abort;
    int n, dones = 0;
    kick(1000);
    repeat (60) @(posedge clk);
    #1 rst = 1;
    #1;
    vec++;
    if ({root, rem, done, busy} !== '0) begin
      errs++;
      $display("FAIL abort_outputs: root=%0h rem=%0h done=%b busy=%b, want all 0", root, rem, done, busy);
    end
    @(negedge clk) rst = 0;
    repeat (140) begin
      @(posedge clk);
      #1 if (done) dones++;
    end
    vec++; if (dones !== 0) begin errs++; $display("FAIL abort_no_done: got %0d dones want 0", dones); end
    kick(16);
    wait_done(n);
    vec++; if (root !== 4 || rem !== 0) begin errs++; $display("FAIL after_abort: root=%0d rem=%0d want 4/0", root, rem); end
  endtask

  task automatic test_exhaustive_w4;
    int n, rt, rm, bad = 0;
    for (int v = 0; v < 256; v++) begin
      @(negedge clk);
      a4 = 8'(v);
      start4 = 1;
      @(posedge clk);
      #1 start4 = 0;
      n = 0;
      while (!done4 && n < 20) begin
        @(posedge clk);
        #1 n++;
      end
      rt = int'(root4);
      rm = int'(rem4);
      vec++;
      if (!done4 || n != 4 || rt * rt > v || v >= (rt + 1) * (rt + 1) || rm != v - rt * rt || rm > 2 * rt) begin
        errs++; bad++;
        if (bad < 5) $display("FAIL w4_a%0d: root=%0d rem=%0d cycles=%0d", v, rt, rm, n);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    test_exhaustive_w4;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
